// File: rtl/apple2_bus_if.sv
// Apple II slot-bus bundle: request/response handshake plus the 6502-side bus pins.
// master is the bus host driving the slot; slave is the requester/card-side view.
interface apple2_bus_if;
    logic        req;
    logic        req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        PHI0;
    logic        PHI1;
    logic [15:0] A;
    logic        nWE;
    logic [7:0]  D_out;
    logic        D_oe;
    logic [7:0]  D_in;
    logic        nDEVSEL;
    logic        nIOSEL;
    logic        nIOSTRB;
    logic        nRESout;

    modport master (
        input  req, req_we, req_addr, req_wdata, D_in,
        output req_ready, rsp_valid, rsp_rdata, PHI0, PHI1, A, nWE,
               D_out, D_oe, nDEVSEL, nIOSEL, nIOSTRB, nRESout
    );

    modport slave (
        output req, req_we, req_addr, req_wdata, D_in,
        input  req_ready, rsp_valid, rsp_rdata, PHI0, PHI1, A, nWE,
               D_out, D_oe, nDEVSEL, nIOSEL, nIOSTRB, nRESout
    );
endinterface

// File: rtl/apple2_bus_host.sv
// Apple II motherboard-side bus host: PHI0/PHI1 sequencing, one-slot select decode, single-byte cycles.
// Request accepted in S7 executes in the following bus cycle; response pulses in the S1 after it; requests wait for the S7 window.
module apple2_bus_host #(
    parameter int          SLOT         = 4,
    parameter bit          LONG_CYCLE   = 1'b1,
    parameter int          RESET_CYCLES = 8,
    parameter logic [15:0] IDLE_ADDR    = 16'hFFFF
) (
    input  logic          C7M,
    input  logic          RES,
    apple2_bus_if.master  bus
);
    typedef enum logic [2:0] {S1, S2, S3, S3X, S4, S5, S6, S7} state_t;

    typedef struct packed {
        logic vld;
        logic we;
    } txn_t;

    localparam logic [11:0] DEV_BASE = 12'hC08 + 12'(SLOT);
    localparam logic [7:0]  IO_BASE  = 8'hC0 + 8'(SLOT);
    localparam logic [15:0] RST_LAST = 16'(RESET_CYCLES - 1);

    state_t      st, nxt_st;
    logic [6:0]  cyc;
    logic [15:0] rst_cnt;
    txn_t        cur;
    logic        accept;
    logic        phi0_nxt;
    logic        dwin_nxt;
    logic        dev_hit, io_hit, strb_hit;

    always_ff @(posedge C7M) begin
        if (RES) st <= S1;
        else     st <= nxt_st;
    end

    always_comb begin
        nxt_st = S1;
        case (st)
            S1:      nxt_st = S2;
            S2:      nxt_st = S3;
            S3:      nxt_st = (LONG_CYCLE && cyc == 7'd64) ? S3X : S4;
            S3X:     nxt_st = S4;
            S4:      nxt_st = S5;
            S5:      nxt_st = S6;
            S6:      nxt_st = S7;
            S7:      nxt_st = S1;
            default: nxt_st = S1;
        endcase
    end

    always_comb begin
        accept   = bus.req && bus.req_ready;
        phi0_nxt = nxt_st inside {S4, S5, S6, S7};
        dwin_nxt = nxt_st inside {S5, S6, S7};
        // Decode the address currently on the bus; A only changes on S1 entry.
        dev_hit  = bus.A[15:4]  == DEV_BASE;
        io_hit   = bus.A[15:8]  == IO_BASE;
        strb_hit = bus.A[15:11] == 5'b11001;
    end

    always_ff @(posedge C7M) begin
        if (RES) begin
            cyc           <= 7'd0;
            rst_cnt       <= 16'd0;
            cur           <= '0;
            bus.PHI0      <= 1'b0;
            bus.PHI1      <= 1'b1;
            bus.A         <= IDLE_ADDR;
            bus.nWE       <= 1'b1;
            bus.D_oe      <= 1'b0;
            bus.D_out     <= 8'd0;
            bus.nDEVSEL   <= 1'b1;
            bus.nIOSEL    <= 1'b1;
            bus.nIOSTRB   <= 1'b1;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 8'd0;
            bus.nRESout   <= 1'b0;
        end else begin
            bus.PHI0      <= phi0_nxt;
            bus.PHI1      <= !phi0_nxt;
            bus.nDEVSEL   <= !(phi0_nxt && dev_hit);
            bus.nIOSEL    <= !(phi0_nxt && io_hit);
            bus.nIOSTRB   <= !(phi0_nxt && strb_hit);
            bus.D_oe      <= dwin_nxt && cur.vld && cur.we;
            bus.req_ready <= (nxt_st == S7) && bus.nRESout;
            bus.rsp_valid <= 1'b0;

            if (st == S7) begin
                cyc           <= (cyc == 7'd64) ? 7'd0 : cyc + 7'd1;
                bus.rsp_valid <= cur.vld;
                if (cur.vld && !cur.we) bus.rsp_rdata <= bus.D_in;
                cur.vld       <= accept;
                cur.we        <= bus.req_we;
                bus.A         <= accept ? bus.req_addr : IDLE_ADDR;
                bus.nWE       <= !(accept && bus.req_we);
                if (accept && bus.req_we) bus.D_out <= bus.req_wdata;
                // Card reset releases on the S1 entry that completes the last idle cycle.
                if (!bus.nRESout) begin
                    if (rst_cnt == RST_LAST) bus.nRESout <= 1'b1;
                    else                     rst_cnt     <= rst_cnt + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_apple2_bus_host.sv
// Bench for apple2_bus_host: randomized slot cycles checked against a range-based reference model.
module tb_apple2_bus_host;
    localparam int SLOT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic res0, res1;
    apple2_bus_if bus0 ();
    apple2_bus_if bus1 ();

    apple2_bus_host #(.SLOT(SLOT), .LONG_CYCLE(1'b0), .RESET_CYCLES(8), .IDLE_ADDR(16'hFFFF))
        dut0 (.C7M(clk), .RES(res0), .bus(bus0));
    apple2_bus_host #(.SLOT(SLOT), .LONG_CYCLE(1'b1), .RESET_CYCLES(8), .IDLE_ADDR(16'hFFFF))
        dut1 (.C7M(clk), .RES(res1), .bus(bus1));

    int checks = 0;
    int errors = 0;
    int tick_no = 0;
    logic [7:0]  exp_rdata;
    logic [7:0]  exp_dout;
    logic [29:0] obs [7];
    logic        rsp_v;
    logic [7:0]  rsp_d;
    int          rsp_t;

    task automatic tick();
        @(posedge clk);
        #1;
        tick_no++;
    endtask

    function automatic logic [29:0] obs_now();
        return {bus0.A, bus0.nWE, bus0.PHI1, bus0.nDEVSEL, bus0.nIOSEL, bus0.nIOSTRB,
                bus0.D_oe, bus0.D_out};
    endfunction

    // Reference: state k (0=S1..6=S7) of a short cycle carrying (we, addr).
    function automatic logic [29:0] exp_vec(input int k, input logic we, input logic [15:0] addr,
                                            input logic [7:0] dout);
        logic ph0, dev, io, strb, oe;
        int a;
        a    = int'(addr);
        ph0  = (k >= 3);
        dev  = ph0 && a >= 'hC080 + 16 * SLOT && a < 'hC080 + 16 * SLOT + 16;
        io   = ph0 && a >= 'hC000 + 256 * SLOT && a < 'hC000 + 256 * SLOT + 256;
        strb = ph0 && a >= 'hC800 && a <= 'hCFFF;
        oe   = we && (k >= 4);
        return {addr, ~we, ~ph0, ~dev, ~io, ~strb, oe, dout};
    endfunction

    task automatic launch(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                          output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus0.req_ready === 1'b1) ok = 1'b1;
            else tick();
        end
        if (ok) begin
            bus0.req       = 1'b1;
            bus0.req_we    = we;
            bus0.req_addr  = addr;
            bus0.req_wdata = wd;
            tick();
            bus0.req = 1'b0;
            if (we) exp_dout = wd;
        end
    endtask

    task automatic run_cycle(input logic [7:0] din, input bit chain, input logic cwe,
                             input logic [15:0] caddr, input logic [7:0] cwd);
        for (int k = 0; k < 7; k++) begin
            obs[k] = obs_now();
            if (k == 6) begin
                bus0.D_in = din;
                if (chain) begin
                    bus0.req       = 1'b1;
                    bus0.req_we    = cwe;
                    bus0.req_addr  = caddr;
                    bus0.req_wdata = cwd;
                end
            end
            tick();
        end
        rsp_v = bus0.rsp_valid;
        rsp_d = bus0.rsp_rdata;
        rsp_t = tick_no;
        if (chain) begin
            bus0.req = 1'b0;
            if (cwe) exp_dout = cwd;
        end
    endtask

    task automatic test_reset();
        logic [41:0] got, want;
        int n, viol;
        res0 = 1'b1;
        tick();
        tick();
        got  = {bus0.PHI1, bus0.PHI0, bus0.A, bus0.nWE, bus0.D_oe, bus0.D_out, bus0.nDEVSEL,
                bus0.nIOSEL, bus0.nIOSTRB, bus0.req_ready, bus0.rsp_valid, bus0.rsp_rdata,
                bus0.nRESout};
        want = {1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_state got %h want %h", got, want);
        end
        res0 = 1'b0;
        n = 0;
        viol = 0;
        while (bus0.nRESout !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (bus0.nRESout !== 1'b1) begin
                if (bus0.req_ready !== 1'b0 || bus0.A !== 16'hFFFF || bus0.rsp_valid !== 1'b0 ||
                    {bus0.nDEVSEL, bus0.nIOSEL, bus0.nIOSTRB} !== 3'b111 || bus0.PHI0 === bus0.PHI1)
                    viol++;
            end
        end
        checks++;
        if (n !== 56) begin
            errors++;
            $display("FAIL nresout_release clocks got %0d want 56", n);
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL reset_hold_idle bad clocks got %0d want 0", viol);
        end
        exp_rdata = 8'h00;
        exp_dout  = 8'h00;
    endtask

    task automatic test_read();
        bit ok;
        launch(1'b0, 16'hC0C3, 8'h00, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL read_accept timeout got %0d want 1", ok);
        end
        run_cycle(8'h5A, 1'b0, 1'b0, 16'h0, 8'h0);
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (obs[k] !== exp_vec(k, 1'b0, 16'hC0C3, exp_dout)) begin
                errors++;
                $display("FAIL read_cycle k=%0d got %h want %h", k, obs[k], exp_vec(k, 1'b0, 16'hC0C3, exp_dout));
            end
        end
        exp_rdata = 8'h5A;
        checks++;
        if (rsp_v !== 1'b1 || rsp_d !== exp_rdata) begin
            errors++;
            $display("FAIL read_rsp got v=%b d=%h want v=1 d=%h", rsp_v, rsp_d, exp_rdata);
        end
        tick();
        checks++;
        if (bus0.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsp_pulse_width got %b want 0", bus0.rsp_valid);
        end
    endtask

    task automatic test_write();
        bit ok;
        launch(1'b1, 16'hC0C0, 8'h12, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL write_accept timeout got %0d want 1", ok);
        end
        run_cycle(8'($urandom), 1'b0, 1'b0, 16'h0, 8'h0);
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (obs[k] !== exp_vec(k, 1'b1, 16'hC0C0, 8'h12)) begin
                errors++;
                $display("FAIL write_cycle k=%0d got %h want %h", k, obs[k], exp_vec(k, 1'b1, 16'hC0C0, 8'h12));
            end
        end
        checks++;
        if (rsp_v !== 1'b1 || rsp_d !== exp_rdata) begin
            errors++;
            $display("FAIL write_rsp got v=%b d=%h want v=1 d=%h", rsp_v, rsp_d, exp_rdata);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int t1;
        logic [7:0] d1, d2, rd1;
        logic rv1;
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        launch(1'b0, 16'hC400, 8'h00, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept timeout got %0d want 1", ok);
        end
        run_cycle(d1, 1'b1, 1'b0, 16'hC800, 8'h00);
        rv1 = rsp_v;
        rd1 = rsp_d;
        t1  = rsp_t;
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (obs[k] !== exp_vec(k, 1'b0, 16'hC400, exp_dout)) begin
                errors++;
                $display("FAIL b2b_first k=%0d got %h want %h", k, obs[k], exp_vec(k, 1'b0, 16'hC400, exp_dout));
            end
        end
        run_cycle(d2, 1'b0, 1'b0, 16'h0, 8'h0);
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (obs[k] !== exp_vec(k, 1'b0, 16'hC800, exp_dout)) begin
                errors++;
                $display("FAIL b2b_second k=%0d got %h want %h", k, obs[k], exp_vec(k, 1'b0, 16'hC800, exp_dout));
            end
        end
        checks++;
        if ({rv1, rd1, rsp_v, rsp_d} !== {1'b1, d1, 1'b1, d2}) begin
            errors++;
            $display("FAIL b2b_rsp got %b/%h %b/%h want 1/%h 1/%h", rv1, rd1, rsp_v, rsp_d, d1, d2);
        end
        checks++;
        if (rsp_t - t1 !== 7) begin
            errors++;
            $display("FAIL b2b_rsp_spacing got %0d want 7", rsp_t - t1);
        end
        exp_rdata = d2;
    endtask

    task automatic test_random();
        bit ok;
        logic we;
        logic [15:0] addr;
        logic [7:0] wd, din;
        int cat, s;
        for (int it = 0; it < 24; it++) begin
            cat = $urandom_range(0, 4);
            case (cat)
                0: addr = 16'(32'hC080 + 16 * SLOT + $urandom_range(0, 15));
                1: addr = 16'(32'hC000 + 256 * SLOT + $urandom_range(0, 255));
                2: addr = 16'(32'hC800 + $urandom_range(0, 2047));
                3: addr = 16'($urandom);
                default: begin
                    s = $urandom_range(1, 6);
                    if (s >= SLOT) s++;
                    addr = 16'(32'hC080 + 16 * s + $urandom_range(0, 15));
                end
            endcase
            we  = 1'($urandom);
            wd  = 8'($urandom);
            din = 8'($urandom);
            launch(we, addr, wd, ok);
            checks++;
            if (ok !== 1'b1) begin
                errors++;
                $display("FAIL rand_accept it=%0d timeout got %0d want 1", it, ok);
            end
            run_cycle(din, 1'b0, 1'b0, 16'h0, 8'h0);
            for (int k = 0; k < 7; k++) begin
                checks++;
                if (obs[k] !== exp_vec(k, we, addr, exp_dout)) begin
                    errors++;
                    $display("FAIL rand_cycle it=%0d k=%0d got %h want %h", it, k, obs[k], exp_vec(k, we, addr, exp_dout));
                end
            end
            if (!we) exp_rdata = din;
            checks++;
            if (rsp_v !== 1'b1 || rsp_d !== exp_rdata) begin
                errors++;
                $display("FAIL rand_rsp it=%0d got v=%b d=%h want v=1 d=%h", it, rsp_v, rsp_d, exp_rdata);
            end
        end
    endtask

    task automatic test_reset_midwrite();
        bit ok;
        bit saw_rv;
        logic [7:0] wd;
        wd = 8'($urandom);
        launch(1'b1, 16'hC0C1, wd, ok);
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if ({ok, bus0.D_oe, bus0.nDEVSEL} !== 3'b110) begin
            errors++;
            $display("FAIL midrst_pre got ok/oe/ndev=%b%b%b want 110", ok, bus0.D_oe, bus0.nDEVSEL);
        end
        res0 = 1'b1;
        tick();
        checks++;
        if ({bus0.nDEVSEL, bus0.D_oe, bus0.nRESout} !== 3'b100) begin
            errors++;
            $display("FAIL midrst_state got ndev/oe/nres=%b%b%b want 100",
                     bus0.nDEVSEL, bus0.D_oe, bus0.nRESout);
        end
        res0 = 1'b0;
        saw_rv = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (bus0.rsp_valid === 1'b1) saw_rv = 1'b1;
            tick();
        end
        checks++;
        if (saw_rv !== 1'b0 || bus0.rsp_rdata !== 8'h00) begin
            errors++;
            $display("FAIL midrst_no_rsp got rv=%b rdata=%h want 0/00", saw_rv, bus0.rsp_rdata);
        end
    endtask

    task automatic test_long_cycle();
        int len, p1, want;
        logic prev;
        res1 = 1'b1;
        tick();
        res1 = 1'b0;
        for (int c = 1; c <= 130; c++) begin
            len = 0;
            p1 = 0;
            do begin
                if (bus1.PHI1 === 1'b1) p1++;
                prev = bus1.PHI1;
                tick();
                len++;
            end while (!(bus1.PHI1 === 1'b1 && prev === 1'b0) && len < 20);
            want = (c % 65 == 0) ? 8 : 7;
            checks++;
            if (len !== want || p1 !== want - 4) begin
                errors++;
                $display("FAIL long_cycle c=%0d got len=%0d phi1=%0d want len=%0d phi1=%0d",
                         c, len, p1, want, want - 4);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        res0 = 1'b1;
        res1 = 1'b1;
        bus0.req = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = 16'h0; bus0.req_wdata = 8'h0; bus0.D_in = 8'h0;
        bus1.req = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = 16'h0; bus1.req_wdata = 8'h0; bus1.D_in = 8'h0;
        exp_rdata = 8'h00;
        exp_dout  = 8'h00;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_random();
        test_reset_midwrite();
        test_long_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
